// File: rtl/fetch_sequencer_pkg.sv
// Shared types for the fetch sequencer: state encoding, defaults, helpers.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN
  } fetch_state_t;

  localparam int unsigned LINE_BYTES_DEF = 64;

  function automatic logic [31:0] line_offset(
    input logic [31:0] addr_lo,
    input int unsigned lb
  );
    return addr_lo & (lb - 32'd1);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Read-cache port between the fetch sequencer (master) and the cache (slave).
interface fetch_sequencer_if #(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned LINE_BYTES = 64
);

  logic                    rd_reqcyc;
  logic [ADDR_W-1:0]       rd_addr;
  logic                    rd_respcyc;
  logic [LINE_BYTES*8-1:0] rd_data;

  modport master (
    output rd_reqcyc,
    output rd_addr,
    input  rd_respcyc,
    input  rd_data
  );

  modport slave (
    input  rd_reqcyc,
    input  rd_addr,
    output rd_respcyc,
    output rd_data
  );

endinterface

// File: rtl/fetch_perf_ctr.sv
// Saturating fetch performance counters, built only with FETCH_PERF_EN.
module fetch_perf_ctr (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc_req,
  input  logic        inc_drop,
  input  logic        inc_stall,
  output logic [31:0] perf_req_cnt,
  output logic [31:0] perf_drop_cnt,
  output logic [31:0] perf_stall_cnt
);

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic        inc
  );
    return (inc && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_req_cnt   <= '0;
      perf_drop_cnt  <= '0;
      perf_stall_cnt <= '0;
    end else begin
      perf_req_cnt   <= sat_inc(perf_req_cnt, inc_req);
      perf_drop_cnt  <= sat_inc(perf_drop_cnt, inc_drop);
      perf_stall_cnt <= sat_inc(perf_stall_cnt, inc_stall);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: issues line reads, aligns/enqueues lines, squashes on redirect.
// Optional perf counters under FETCH_PERF_EN.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned LINE_BYTES      = LINE_BYTES_DEF,
  parameter int unsigned REQ_THRESH_BITS = 512,
  parameter int unsigned ADDR_W          = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       entry,
  input  logic                    redirect_valid,
  input  logic [ADDR_W-1:0]       redirect_addr,
  input  logic [31:0]             fq_empty_cnt,
  fetch_sequencer_if.master       rd,
  output logic                    fq_enq,
  output logic [31:0]             fq_in_cnt,
  output logic [LINE_BYTES*8-1:0] fq_in_data,
  output logic                    fq_flush
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]             perf_req_cnt,
  output logic [31:0]             perf_drop_cnt,
  output logic [31:0]             perf_stall_cnt
`endif
);

  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);
  localparam logic [ADDR_W-1:0] LINE_INC  = ADDR_W'(LINE_BYTES);
  localparam logic [31:0] LINE_BITS = 32'(LINE_BYTES * 8);
  localparam logic [31:0] THRESH    = 32'(REQ_THRESH_BITS);
  localparam logic [31:0] THRESH2   = 32'(2 * REQ_THRESH_BITS);

  fetch_state_t      state_q;
  fetch_state_t      state_d;
  logic [ADDR_W-1:0] fetch_addr_ff;
  logic [ADDR_W-1:0] fetch_addr_d;
  logic [ADDR_W-1:0] req_line_ff;
  logic              load_line;
  logic              drop;
  logic              stall;
  logic [31:0]       off;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      fetch_addr_ff <= entry;
      req_line_ff   <= entry & LINE_MASK;
    end else begin
      state_q       <= state_d;
      fetch_addr_ff <= fetch_addr_d;
      if (load_line)
        req_line_ff <= fetch_addr_d & LINE_MASK;
    end
  end

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_ff;
    fq_enq       = 1'b0;
    fq_flush     = redirect_valid;
    drop         = 1'b0;
    stall        = 1'b0;
    if (redirect_valid)
      fetch_addr_d = redirect_addr;
    unique case (state_q)
      IDLE: begin
        stall = fq_empty_cnt < THRESH;
        if (!redirect_valid && !stall)
          state_d = REQ;
      end
      REQ: begin
        if (redirect_valid) begin
          drop    = rd.rd_respcyc;
          state_d = rd.rd_respcyc ? IDLE : DRAIN;
        end else if (rd.rd_respcyc) begin
          fq_enq       = 1'b1;
          fetch_addr_d = (fetch_addr_ff & LINE_MASK) + LINE_INC;
          // Threshold doubled: the line enqueued now still occupies space
          state_d = (fq_empty_cnt >= THRESH2) ? REQ : IDLE;
        end
      end
      DRAIN: begin
        if (rd.rd_respcyc) begin
          drop    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // New line is captured only when a fresh request is issued
  assign load_line = (state_d == REQ) &&
                     (state_q == IDLE || rd.rd_respcyc);

  assign rd.rd_reqcyc = (state_q != IDLE);
  assign rd.rd_addr   = (state_q != IDLE) ? req_line_ff
                                          : (fetch_addr_ff & LINE_MASK);

  assign off        = line_offset(fetch_addr_ff[31:0], LINE_BYTES);
  assign fq_in_cnt  = LINE_BITS - (off << 3);
  assign fq_in_data = rd.rd_data << (off << 3);

  a_no_idle_resp: assert property (
    @(posedge clk) disable iff (!reset)
    !(state_q == IDLE && rd.rd_respcyc)
  );

`ifdef FETCH_PERF_EN
  fetch_perf_ctr u_perf (
    .clk            (clk),
    .reset          (reset),
    .inc_req        (load_line),
    .inc_drop       (drop),
    .inc_stall      (stall),
    .perf_req_cnt   (perf_req_cnt),
    .perf_drop_cnt  (perf_drop_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );
`else
  logic unused_perf;
  assign unused_perf = drop ^ stall;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: fetch, threshold, redirects, wrap, reset.
module tb_fetch_sequencer;

  logic         clk;
  logic         reset;
  logic [63:0]  entry;
  logic         redirect_valid;
  logic [63:0]  redirect_addr;
  logic [31:0]  fq_empty_cnt;
  logic         fq_enq;
  logic [31:0]  fq_in_cnt;
  logic [511:0] fq_in_data;
  logic         fq_flush;
  logic [511:0] pat;
  int           checks;
  int           failures;
`ifdef FETCH_PERF_EN
  logic [31:0]  perf_req_cnt;
  logic [31:0]  perf_drop_cnt;
  logic [31:0]  perf_stall_cnt;
`endif

  fetch_sequencer_if #(.ADDR_W(64), .LINE_BYTES(64)) rd_bus ();

  fetch_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .entry          (entry),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .fq_empty_cnt   (fq_empty_cnt),
    .rd             (rd_bus),
    .fq_enq         (fq_enq),
    .fq_in_cnt      (fq_in_cnt),
    .fq_in_data     (fq_in_data),
    .fq_flush       (fq_flush)
`ifdef FETCH_PERF_EN
    ,
    .perf_req_cnt   (perf_req_cnt),
    .perf_drop_cnt  (perf_drop_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic test_reset;
    @(negedge clk); #1;
    checks++;
    if (rd_bus.rd_reqcyc !== 1'b0) begin
      failures++; $display("FAIL rst_reqcyc got=%0b exp=0", rd_bus.rd_reqcyc);
    end
    checks++;
    if (fq_enq !== 1'b0 || fq_flush !== 1'b0) begin
      failures++; $display("FAIL rst_enq_flush got=%0b%0b exp=00", fq_enq, fq_flush);
    end
    checks++;
    if (rd_bus.rd_addr !== 64'h40_0000) begin
      failures++; $display("FAIL rst_addr got=%h exp=400000", rd_bus.rd_addr);
    end
  endtask

  task automatic test_first_fetch;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (rd_bus.rd_reqcyc !== 1'b1 || rd_bus.rd_addr !== 64'h40_0000) begin
      failures++; $display("FAIL first_req got=%0b/%h exp=1/400000", rd_bus.rd_reqcyc, rd_bus.rd_addr);
    end
    rd_bus.rd_respcyc = 1'b1; rd_bus.rd_data = pat; #1;
    checks++;
    if (fq_enq !== 1'b1 || fq_flush !== 1'b0) begin
      failures++; $display("FAIL first_enq got=%0b%0b exp=10", fq_enq, fq_flush);
    end
    checks++;
    if (fq_in_cnt !== 32'd384) begin
      failures++; $display("FAIL first_cnt got=%0d exp=384", fq_in_cnt);
    end
    checks++;
    if (fq_in_data !== (pat << 128)) begin
      failures++; $display("FAIL first_data got=%h exp=%h", fq_in_data[511:384], pat[383:256]);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk); rd_bus.rd_respcyc = 1'b0; #1;
    checks++;
    if (rd_bus.rd_reqcyc !== 1'b1 || rd_bus.rd_addr !== 64'h40_0040) begin
      failures++; $display("FAIL b2b_req got=%0b/%h exp=1/400040", rd_bus.rd_reqcyc, rd_bus.rd_addr);
    end
    fq_empty_cnt = 32'd600; rd_bus.rd_respcyc = 1'b1; rd_bus.rd_data = ~pat; #1;
    checks++;
    if (fq_enq !== 1'b1 || fq_in_cnt !== 32'd512 || fq_in_data !== ~pat) begin
      failures++; $display("FAIL b2b_enq got=%0b/%0d exp=1/512", fq_enq, fq_in_cnt);
    end
  endtask

  task automatic test_threshold;
    @(negedge clk); rd_bus.rd_respcyc = 1'b0; fq_empty_cnt = 32'd100; #1;
    checks++;
    if (rd_bus.rd_reqcyc !== 1'b0 || rd_bus.rd_addr !== 64'h40_0080) begin
      failures++; $display("FAIL thr_idle got=%0b/%h exp=0/400080", rd_bus.rd_reqcyc, rd_bus.rd_addr);
    end
    @(negedge clk); #1;
    checks++;
    if (rd_bus.rd_reqcyc !== 1'b0) begin
      failures++; $display("FAIL thr_hold got=%0b exp=0", rd_bus.rd_reqcyc);
    end
    fq_empty_cnt = 32'd1024;
    @(negedge clk); #1;
    checks++;
    if (rd_bus.rd_reqcyc !== 1'b1 || rd_bus.rd_addr !== 64'h40_0080) begin
      failures++; $display("FAIL thr_rise got=%0b/%h exp=1/400080", rd_bus.rd_reqcyc, rd_bus.rd_addr);
    end
  endtask

  task automatic test_redirect_drain;
    @(negedge clk); redirect_valid = 1'b1; redirect_addr = 64'h50_0008; #1;
    checks++;
    if (fq_flush !== 1'b1 || fq_enq !== 1'b0) begin
      failures++; $display("FAIL rdr_flush got=%0b%0b exp=10", fq_flush, fq_enq);
    end
    @(negedge clk); redirect_valid = 1'b0; #1;
    checks++;
    if (fq_flush !== 1'b0 || rd_bus.rd_reqcyc !== 1'b1 || rd_bus.rd_addr !== 64'h40_0080) begin
      failures++; $display("FAIL rdr_drain got=%0b/%0b/%h exp=0/1/400080", fq_flush, rd_bus.rd_reqcyc, rd_bus.rd_addr);
    end
    @(negedge clk);
    @(negedge clk); rd_bus.rd_respcyc = 1'b1; rd_bus.rd_data = pat; #1;
    checks++;
    if (fq_enq !== 1'b0 || fq_flush !== 1'b0) begin
      failures++; $display("FAIL rdr_drop got=%0b%0b exp=00", fq_enq, fq_flush);
    end
    @(negedge clk); rd_bus.rd_respcyc = 1'b0; #1;
    checks++;
    if (rd_bus.rd_reqcyc !== 1'b0 || rd_bus.rd_addr !== 64'h50_0000) begin
      failures++; $display("FAIL rdr_idle got=%0b/%h exp=0/500000", rd_bus.rd_reqcyc, rd_bus.rd_addr);
    end
    @(negedge clk); #1;
    checks++;
    if (rd_bus.rd_reqcyc !== 1'b1 || rd_bus.rd_addr !== 64'h50_0000) begin
      failures++; $display("FAIL rdr_req got=%0b/%h exp=1/500000", rd_bus.rd_reqcyc, rd_bus.rd_addr);
    end
    rd_bus.rd_respcyc = 1'b1; fq_empty_cnt = 32'd100; #1;
    checks++;
    if (fq_enq !== 1'b1 || fq_in_cnt !== 32'd448 || fq_in_data !== (pat << 64)) begin
      failures++; $display("FAIL rdr_enq got=%0b/%0d exp=1/448", fq_enq, fq_in_cnt);
    end
  endtask

  task automatic test_redirect_coincident;
    @(negedge clk); rd_bus.rd_respcyc = 1'b0; fq_empty_cnt = 32'd1024;
    @(negedge clk); #1;
    checks++;
    if (rd_bus.rd_reqcyc !== 1'b1 || rd_bus.rd_addr !== 64'h50_0040) begin
      failures++; $display("FAIL coin_req got=%0b/%h exp=1/500040", rd_bus.rd_reqcyc, rd_bus.rd_addr);
    end
    rd_bus.rd_respcyc = 1'b1; redirect_valid = 1'b1; redirect_addr = 64'h60_0020; #1;
    checks++;
    if (fq_enq !== 1'b0 || fq_flush !== 1'b1) begin
      failures++; $display("FAIL coin_out got=%0b%0b exp=01", fq_enq, fq_flush);
    end
    @(negedge clk); rd_bus.rd_respcyc = 1'b0; redirect_valid = 1'b0; fq_empty_cnt = 32'd100; #1;
    checks++;
    if (rd_bus.rd_reqcyc !== 1'b0 || rd_bus.rd_addr !== 64'h60_0000) begin
      failures++; $display("FAIL coin_idle got=%0b/%h exp=0/600000", rd_bus.rd_reqcyc, rd_bus.rd_addr);
    end
    fq_empty_cnt = 32'd1024;
    @(negedge clk); #1;
    checks++;
    if (rd_bus.rd_reqcyc !== 1'b1 || rd_bus.rd_addr !== 64'h60_0000) begin
      failures++; $display("FAIL coin_req2 got=%0b/%h exp=1/600000", rd_bus.rd_reqcyc, rd_bus.rd_addr);
    end
    rd_bus.rd_respcyc = 1'b1; fq_empty_cnt = 32'd100; #1;
    checks++;
    if (fq_enq !== 1'b1 || fq_in_cnt !== 32'd256 || fq_in_data !== (pat << 256)) begin
      failures++; $display("FAIL coin_enq got=%0b/%0d exp=1/256", fq_enq, fq_in_cnt);
    end
    @(negedge clk); rd_bus.rd_respcyc = 1'b0;
  endtask

  task automatic test_wrap;
    entry = 64'hFFFF_FFFF_FFFF_FFC0; reset = 1'b0; fq_empty_cnt = 32'd2048; #1;
    checks++;
    if (rd_bus.rd_reqcyc !== 1'b0 || rd_bus.rd_addr !== 64'hFFFF_FFFF_FFFF_FFC0) begin
      failures++; $display("FAIL wrap_rst got=%0b/%h exp=0/ffffffffffffffc0", rd_bus.rd_reqcyc, rd_bus.rd_addr);
    end
    @(negedge clk); reset = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (rd_bus.rd_reqcyc !== 1'b1 || rd_bus.rd_addr !== 64'hFFFF_FFFF_FFFF_FFC0) begin
      failures++; $display("FAIL wrap_req1 got=%0b/%h exp=1/ffffffffffffffc0", rd_bus.rd_reqcyc, rd_bus.rd_addr);
    end
    rd_bus.rd_respcyc = 1'b1; rd_bus.rd_data = pat; #1;
    checks++;
    if (fq_enq !== 1'b1 || fq_in_cnt !== 32'd512) begin
      failures++; $display("FAIL wrap_enq1 got=%0b/%0d exp=1/512", fq_enq, fq_in_cnt);
    end
    @(negedge clk); rd_bus.rd_respcyc = 1'b0; #1;
    checks++;
    if (rd_bus.rd_reqcyc !== 1'b1 || rd_bus.rd_addr !== 64'h0) begin
      failures++; $display("FAIL wrap_req2 got=%0b/%h exp=1/0", rd_bus.rd_reqcyc, rd_bus.rd_addr);
    end
    rd_bus.rd_respcyc = 1'b1; fq_empty_cnt = 32'd100;
    @(negedge clk); rd_bus.rd_respcyc = 1'b0; #1;
    checks++;
    if (rd_bus.rd_reqcyc !== 1'b0 || rd_bus.rd_addr !== 64'h40) begin
      failures++; $display("FAIL wrap_idle got=%0b/%h exp=0/40", rd_bus.rd_reqcyc, rd_bus.rd_addr);
    end
  endtask

  task automatic test_reset_in_drain;
    fq_empty_cnt = 32'd1024;
    @(negedge clk); #1;
    checks++;
    if (rd_bus.rd_reqcyc !== 1'b1 || rd_bus.rd_addr !== 64'h40) begin
      failures++; $display("FAIL rid_req got=%0b/%h exp=1/40", rd_bus.rd_reqcyc, rd_bus.rd_addr);
    end
    redirect_valid = 1'b1; redirect_addr = 64'h70_0000;
    @(negedge clk); redirect_valid = 1'b0; #1;
    checks++;
    if (rd_bus.rd_reqcyc !== 1'b1 || rd_bus.rd_addr !== 64'h40) begin
      failures++; $display("FAIL rid_drain got=%0b/%h exp=1/40", rd_bus.rd_reqcyc, rd_bus.rd_addr);
    end
    entry = 64'h80_0004; reset = 1'b0; #1;
    checks++;
    if (rd_bus.rd_reqcyc !== 1'b0 || fq_enq !== 1'b0 || fq_flush !== 1'b0 ||
        rd_bus.rd_addr !== 64'h80_0000) begin
      failures++; $display("FAIL rid_rst got=%0b%0b%0b/%h exp=000/800000", rd_bus.rd_reqcyc, fq_enq, fq_flush, rd_bus.rd_addr);
    end
`ifdef FETCH_PERF_EN
    checks++;
    if (perf_drop_cnt !== 32'd0) begin
      failures++; $display("FAIL rid_perf_drop got=%0d exp=0", perf_drop_cnt);
    end
`endif
    @(negedge clk); reset = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (rd_bus.rd_reqcyc !== 1'b1 || rd_bus.rd_addr !== 64'h80_0000) begin
      failures++; $display("FAIL rid_req2 got=%0b/%h exp=1/800000", rd_bus.rd_reqcyc, rd_bus.rd_addr);
    end
    rd_bus.rd_respcyc = 1'b1; fq_empty_cnt = 32'd100; #1;
    checks++;
    if (fq_enq !== 1'b1 || fq_in_cnt !== 32'd480 || fq_in_data !== (pat << 32)) begin
      failures++; $display("FAIL rid_enq got=%0b/%0d exp=1/480", fq_enq, fq_in_cnt);
    end
    @(negedge clk); rd_bus.rd_respcyc = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 16; i++)
      pat[i*32 +: 32] = (32'h0101_0101 * (i + 1)) ^ 32'hA5A5_5A5A;
    reset = 1'b0;
    entry = 64'h40_0010;
    redirect_valid = 1'b0;
    redirect_addr = '0;
    fq_empty_cnt = 32'd2048;
    rd_bus.rd_respcyc = 1'b0;
    rd_bus.rd_data = '0;
    test_reset();
    test_first_fetch();
    test_back_to_back();
    test_threshold();
    test_redirect_drain();
    test_redirect_coincident();
    test_wrap();
    test_reset_in_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

`ifdef FETCH_PERF_EN
  final $display("perf req=%0d drop=%0d stall=%0d", perf_req_cnt, perf_drop_cnt, perf_stall_cnt);
`endif

endmodule
